regfile_read_port: RTL and testbench

- Register bank of NREGS 32-bit registers with one write port and a dual-operand read port, serving operand fetch for the ALU.
- Each read request carries two addresses and returns both operands one cycle later through a valid/ready handshake.
- Includes write-to-read forwarding for same-cycle writes and a hardwired zero register.
- Sits between the writeback path (writer) and the ALU operand stage (reader).

---
 rtl/alu_pkg.sv | 17 +
 rtl/regfile_read_port_reg_bank.sv | 40 ++++
 rtl/regfile_read_port.sv | 84 ++++++++
 tb/tb_regfile_read_port.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and default sizes for the ALU operand register file.
// Provides the data word type, default bank geometry and the read request bundle.
package alu_pkg;

    localparam int DATA_W    = 32;
    localparam int NREGS_DEF = 32;
    localparam int AW_DEF    = $clog2(NREGS_DEF);

    typedef logic [DATA_W-1:0] word_t;

    // Read request bundle for the default geometry.
    typedef struct packed {
        logic [AW_DEF-1:0] a;
        logic [AW_DEF-1:0] b;
    } rd_req_t;

endpackage

// File: rtl/regfile_read_port_reg_bank.sv
// reg_bank: NREGS x 32-bit storage, one write port, two combinational read taps.
// Ports: clk, rst_n, we/wr_addr/wr_data (write), rd_addr_a/b -> rd_data_a/b (read).
module reg_bank
    import alu_pkg::*;
#(
    parameter int NREGS    = NREGS_DEF,
    parameter int AW       = $clog2(NREGS),
    parameter int ZERO_REG = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  word_t         wr_data,
    input  logic [AW-1:0] rd_addr_a,
    input  logic [AW-1:0] rd_addr_b,
    output word_t         rd_data_a,
    output word_t         rd_data_b
);

    word_t mem [NREGS];
    logic  wr_ok;

    // Writes to the hardwired zero register never reach storage.
    assign wr_ok = we && !((ZERO_REG != 0) && (wr_addr == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data_a = mem[rd_addr_a];
    assign rd_data_b = mem[rd_addr_b];

endmodule

// File: rtl/regfile_read_port.sv
// regfile_read_port: register bank with a dual-operand read port and 1-cycle response.
// Ports: clk, rst_n, writeEnable/wr_addr/wr_data, req_* (request), rsp_* (response).
module regfile_read_port
    import alu_pkg::*;
#(
    parameter int NREGS    = NREGS_DEF,
    parameter int AW       = $clog2(NREGS),
    parameter int ZERO_REG = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          writeEnable,
    input  logic [AW-1:0] wr_addr,
    input  word_t         wr_data,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [AW-1:0] req_addr_a,
    input  logic [AW-1:0] req_addr_b,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output word_t         rsp_data_a,
    output word_t         rsp_data_b
);

    word_t bank_a;
    word_t bank_b;
    word_t op_a;
    word_t op_b;
    logic  accept;

    reg_bank #(
        .NREGS    (NREGS),
        .AW       (AW),
        .ZERO_REG (ZERO_REG)
    ) u_bank (
        .clk       (clk),
        .rst_n     (rst_n),
        .we        (writeEnable),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr_a (req_addr_a),
        .rd_addr_b (req_addr_b),
        .rd_data_a (bank_a),
        .rd_data_b (bank_b)
    );

    // Single response slot: a new request fits once the current one retires.
    assign req_ready = !rsp_valid || rsp_ready;
    assign accept    = req_valid && req_ready;

    // Forward a same-cycle write; zero register overrides forwarding.
    always_comb begin
        op_a = bank_a;
        op_b = bank_b;
        if (writeEnable && (wr_addr == req_addr_a)) begin
            op_a = wr_data;
        end
        if (writeEnable && (wr_addr == req_addr_b)) begin
            op_b = wr_data;
        end
        if ((ZERO_REG != 0) && (req_addr_a == '0)) begin
            op_a = '0;
        end
        if ((ZERO_REG != 0) && (req_addr_b == '0)) begin
            op_b = '0;
        end
    end

    // Operands are snapshotted at acceptance and held until retired.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid  <= 1'b0;
            rsp_data_a <= '0;
            rsp_data_b <= '0;
        end else if (accept) begin
            rsp_valid  <= 1'b1;
            rsp_data_a <= op_a;
            rsp_data_b <= op_b;
        end else if (rsp_ready) begin
            rsp_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_read_port.sv
// Randomized and directed bench for regfile_read_port against a behavioural model.
// Model: array of register values plus the single expected response slot.
module tb_regfile_read_port;

    localparam int NR = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        writeEnable;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_addr_a;
    logic [4:0]  req_addr_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data_a;
    logic [31:0] rsp_data_b;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] model [NR];
    logic        exp_v;
    logic [31:0] exp_a;
    logic [31:0] exp_b;

    always #5 clk = ~clk;

    regfile_read_port #(
        .NREGS    (NR),
        .ZERO_REG (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .writeEnable (writeEnable),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr_a  (req_addr_a),
        .req_addr_b  (req_addr_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data_a  (rsp_data_a),
        .rsp_data_b  (rsp_data_b)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_read(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (writeEnable && wr_addr == a) return wr_data;
        return model[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NR; i++) model[i] = 32'h0;
        exp_v = 1'b0;
        exp_a = 32'h0;
        exp_b = 32'h0;
    endtask

    // One clock: called at a negedge with inputs already driven.
    task automatic cycle();
        logic        acc;
        logic [31:0] na;
        logic [31:0] nb;
        #1;
        check("req_ready", {31'b0, req_ready}, {31'b0, !exp_v || rsp_ready});
        acc = req_valid && (!exp_v || rsp_ready);
        na  = ref_read(req_addr_a);
        nb  = ref_read(req_addr_b);
        @(posedge clk);
        if (acc) begin
            exp_v = 1'b1;
            exp_a = na;
            exp_b = nb;
        end else if (rsp_ready) begin
            exp_v = 1'b0;
        end
        if (writeEnable && wr_addr != 5'd0) model[wr_addr] = wr_data;
        #1;
        check("rsp_valid", {31'b0, rsp_valid}, {31'b0, exp_v});
        if (exp_v) begin
            check("rsp_data_a", rsp_data_a, exp_a);
            check("rsp_data_b", rsp_data_b, exp_b);
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic rv,
                         input logic [4:0] ra, input logic [4:0] rb,
                         input logic rr);
        writeEnable = we;
        wr_addr     = wa;
        wr_data     = wd;
        req_valid   = rv;
        req_addr_a  = ra;
        req_addr_b  = rb;
        rsp_ready   = rr;
        cycle();
    endtask

    task automatic idle_inputs();
        writeEnable = 1'b0;
        wr_addr     = 5'd0;
        wr_data     = 32'h0;
        req_valid   = 1'b0;
        req_addr_a  = 5'd0;
        req_addr_b  = 5'd0;
        rsp_ready   = 1'b1;
    endtask

    // Assert reset between edges and check the asynchronous effect.
    task automatic reset_mid();
        idle_inputs();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_valid", {31'b0, rsp_valid}, 32'h0);
        check("rst_data_a", rsp_data_a, 32'h0);
        check("rst_data_b", rsp_data_b, 32'h0);
        model_clear();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        model_clear();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("init_valid", {31'b0, rsp_valid}, 32'h0);

        // Reset mid-cycle and idle read
        reset_mid();
        drive(0, 0, 0, 1, 5, 7, 1);
        check("idle_a", rsp_data_a, 32'h0);
        check("idle_b", rsp_data_b, 32'h0);

        // Write then read, zero register write dropped
        drive(1, 3, 32'hDEADBEEF, 0, 0, 0, 1);
        drive(0, 0, 0, 1, 3, 0, 1);
        check("wr_rd_a", rsp_data_a, 32'hDEADBEEF);
        check("wr_rd_b", rsp_data_b, 32'h0);
        drive(1, 0, 32'h1234, 0, 0, 0, 1);
        drive(0, 0, 0, 1, 0, 3, 1);
        check("zero_a", rsp_data_a, 32'h0);

        // Forwarding, zero priority over forwarding
        drive(1, 9, 32'h1, 0, 0, 0, 1);
        drive(1, 9, 32'hA5A5A5A5, 1, 9, 9, 1);
        check("fwd_a", rsp_data_a, 32'hA5A5A5A5);
        check("fwd_b", rsp_data_b, 32'hA5A5A5A5);
        drive(1, 0, 32'hFFFF, 1, 0, 9, 1);
        check("fwd_zero", rsp_data_a, 32'h0);

        // Backpressure
        drive(1, 4, 32'h11, 0, 0, 0, 1);
        drive(0, 0, 0, 1, 4, 4, 1);
        for (int i = 0; i < 3; i++) begin
            drive(1, 4, 32'h22, 1, 9, 3, 0);
            check("bp_ready", {31'b0, req_ready}, 32'h0);
            check("bp_hold", rsp_data_a, 32'h11);
        end
        drive(0, 0, 0, 0, 0, 0, 1);
        check("bp_retire", {31'b0, rsp_valid}, 32'h0);
        drive(0, 0, 0, 1, 4, 0, 1);
        check("bp_new", rsp_data_a, 32'h22);

        // Streaming
        for (int i = 1; i <= 8; i++) begin
            drive(1, 5'(i), 32'(i * 10), 0, 0, 0, 1);
        end
        for (int i = 1; i <= 8; i++) begin
            drive(0, 0, 0, 1, 5'(i), 5'(9 - i), 1);
            check("stream_a", rsp_data_a, 32'(i * 10));
        end
        drive(0, 0, 0, 0, 0, 0, 1);

        // Reset mid-operation
        drive(0, 0, 0, 1, 3, 4, 0);
        reset_mid();
        for (int i = 0; i < NR; i += 2) begin
            drive(0, 0, 0, 1, 5'(i), 5'(i + 1), 1);
            check("post_rst_a", rsp_data_a, 32'h0);
            check("post_rst_b", rsp_data_b, 32'h0);
        end

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            drive(1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 7)),
                  $urandom,
                  1'($urandom_range(0, 3) != 0),
                  5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)),
                  1'($urandom_range(0, 2) != 0));
            if (n == 300) reset_mid();
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
